uart_rx_os: RTL and testbench
=============================

Name: uart_rx_os

Overview:
Parametrised next-generation UART receiver for the full-duplex UART IP core.
- Replaces the fixed-format receiver with one that supports 5-8 data bits, none/even/odd parity and 1 or 2 stop bits.
- Uses a programmable divisor, 16x oversampling with 3-sample majority vote, and a per-entry-flagged RX FIFO with a valid/ready output.
- Sits between the pad-side rx line and the bus/register interface.

Parameters:
DIV_W, 16, width of the baud divisor input.
FIFO_DEPTH, 16, RX FIFO entries; power of 2, minimum 2.
SYNC_STAGES, 2, number of rx synchroniser flops; minimum 2.

Ports:
clk  in  1  system clock (50 MHz nominal).
rstn  in  1  synchronous, active-low reset.
rx  in  1  serial input, asynchronous, idles high.
baud_div  in  DIV_W  oversample tick period minus 1, in clk cycles (tick every baud_div+1 cycles).
data_bits  in  2  00=5, 01=6, 10=7, 11=8 data bits.
parity_en  in  1  1 = parity bit present.
parity_type  in  1  0 = even, 1 = odd.
stop_bits  in  1  0 = one stop bit, 1 = two stop bits.
m_data  out  8  received data, LSB first; unused upper bits forced to 0.
m_flags  out  3  {break, frame_err, parity_err} for the head entry.
m_valid  out  1  FIFO not empty.
m_ready  in  1  consumer accepts the head entry when m_valid is high.
fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy.
busy  out  1  high in any state other than IDLE.
start_err  out  1  one-cycle pulse on a false start bit.
overrun  out  1  one-cycle pulse when a completed frame is dropped because the FIFO is full.

Behaviour:
- Reset (rstn=0 sampled on a clk edge):
  - State goes to IDLE; FIFO is emptied; tick counter and bit counter clear.
  - Synchroniser flops load 1.
  - Outputs: m_valid=0, m_data=0, m_flags=0, fifo_count=0, busy=0, start_err=0, overrun=0.
  - Reset mid-frame abandons the frame; nothing is pushed.
- Tick generator: free-running counter, 0..baud_div; tick=1 for one clk when the count wraps. baud_div=0 gives a tick every clk.
- Sampling: each bit spans 16 ticks (index 0-15). The bit value is the majority of the synchronised rx at ticks 7, 8 and 9, and is resolved at tick 9.
- Configuration: data_bits, parity_en, parity_type and stop_bits are latched on start detect. Changes mid-frame have no effect until the next frame.
- FSM:
  - IDLE: synchronised rx=0 → START, with the tick index reset to 0.
  - START: at tick 9, majority=1 → pulse start_err, return to IDLE; else at tick 15 → DATA.
  - DATA: shift in LSB first. After N bits (N from latched data_bits) → PARITY if parity_en, else STOP.
  - PARITY: compute XOR of the data bits and the parity bit. Expected result is 0 for even, 1 for odd; a mismatch sets parity_err.
  - STOP: at tick 9, majority=0 sets frame_err. With stop_bits=1, continue to STOP2 at tick 15; otherwise finish.
  - STOP2: checked the same way as STOP; frame_err is set if either stop bit is 0.
  - Finish: push the entry in the clk after the final stop sample. If break is set → BRK_WAIT; else → IDLE. The frame ends mid-stop-bit so the receiver can resync to a following start bit.
  - BRK_WAIT: stay until synchronised rx=1, then → IDLE.
- Break condition: all data bits 0, parity bit 0 (if present) and all stop bits 0.
- FIFO:
  - An entry holds {break, frame_err, parity_err, data[7:0]} (11 bits).
  - A pushed entry is visible on m_valid/m_data in the clk after the push (1-cycle latency).
  - m_data and m_flags always show the head entry.
  - Pop occurs when m_valid & m_ready.
  - Full and a push pending: frame dropped, overrun pulses, contents unchanged.
  - Full with simultaneous push and pop: both occur; count stays at FIFO_DEPTH; no overrun.
  - Empty with m_ready=1: no effect.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- Error flags never block the push; data is always delivered alongside its flags.

Test Plan:
- 8E1, baud_div=325 (9600 baud at 50 MHz), send 0xA3 with parity bit 0 → one entry: m_data=0xA3, m_flags=000, fifo_count=1, busy falls after the stop-bit sample.
- 8O1, baud_div=162 (19200), send 0xA3 with parity bit 0 → m_data=0xA3, m_flags=001. Repeat with parity bit 1 → m_flags=000.
- 7N2, send 0x55 with the second stop bit 0 → m_data=0x55, m_flags=010. Then 5N1, send 0x1F → m_data=0x1F with upper bits 0, m_flags=000.
- rx low for 3 ticks only → start_err single pulse, no push, back in IDLE. Reset asserted mid-DATA → fifo_count=0, busy=0, no entry.
- m_ready=0, send 17 frames 0x00..0x10 → fifo_count=16, one overrun pulse on the 17th. Drain → 0x00..0x0F in order. Full-plus-pop same cycle → count holds at 16, no overrun.
- Hold rx low for 2 frame times (8E1), then high → exactly one entry: m_data=0x00, m_flags=110. No further entries until rx returns high and a new start bit arrives.

Source files
------------

// File: rtl/uart_rx_os.sv
// uart_rx_os: 16x-oversampled UART receiver with a programmable frame format
// (5-8 data bits, optional even/odd parity, 1 or 2 stop bits) feeding a flagged RX FIFO.
module uart_rx_os #(
  parameter int DIV_W       = 16,
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        rx,
  input  logic [DIV_W-1:0]            baud_div,
  input  logic [1:0]                  data_bits,
  input  logic                        parity_en,
  input  logic                        parity_type,
  input  logic                        stop_bits,
  output logic [7:0]                  m_data,
  output logic [2:0]                  m_flags,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        busy,
  output logic                        start_err,
  output logic                        overrun
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_START    = 3'd1,
    S_DATA     = 3'd2,
    S_PARITY   = 3'd3,
    S_STOP     = 3'd4,
    S_STOP2    = 3'd5,
    S_BRK_WAIT = 3'd6
  } state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [DIV_W-1:0]       div_cnt_q, div_cnt_d;
  logic [3:0]             idx_q, idx_d;
  logic                   s7_q, s7_d, s8_q, s8_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [2:0]             last_bit_q, last_bit_d;
  logic                   par_en_q, par_en_d, par_type_q, par_type_d, stop2_q, stop2_d;
  logic [7:0]             data_q, data_d;
  logic                   par_acc_q, par_acc_d, any_one_q, any_one_d;
  logic                   ferr_q, ferr_d, perr_q, perr_d;
  logic                   push_q, push_d;
  logic [10:0]            entry_q, entry_d;
  logic                   start_err_q, start_err_d, overrun_q, overrun_d;
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic [10:0]            mem_q [FIFO_DEPTH];
  logic [10:0]            mem_d [FIFO_DEPTH];

  logic rx_s, tick_s, maj_s, sample_s, bit_end_s, finish_s;
  logic full_s, pop_s, wr_s;
  logic [10:0] head_s;

  assign rx_s = sync_q[SYNC_STAGES-1];

  // Synchroniser shift and free-running oversample tick divider.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], rx};
    if (div_cnt_q >= baud_div) begin
      tick_s    = 1'b1;
      div_cnt_d = {DIV_W{1'b0}};
    end else begin
      tick_s    = 1'b0;
      div_cnt_d = div_cnt_q + {{(DIV_W-1){1'b0}}, 1'b1};
    end
  end

  // Frame FSM: next state, bit assembly and error accumulation.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    s7_d        = s7_q;
    s8_d        = s8_q;
    bit_cnt_d   = bit_cnt_q;
    last_bit_d  = last_bit_q;
    par_en_d    = par_en_q;
    par_type_d  = par_type_q;
    stop2_d     = stop2_q;
    data_d      = data_q;
    par_acc_d   = par_acc_q;
    any_one_d   = any_one_q;
    ferr_d      = ferr_q;
    perr_d      = perr_q;
    entry_d     = entry_q;
    push_d      = 1'b0;
    start_err_d = 1'b0;
    finish_s    = 1'b0;
    maj_s       = maj3(s7_q, s8_q, rx_s);
    sample_s    = tick_s && (idx_q == 4'd9);
    bit_end_s   = tick_s && (idx_q == 4'd15);

    if (tick_s) begin
      idx_d = idx_q + 4'd1;
      if (idx_q == 4'd7) begin
        s7_d = rx_s;
      end else if (idx_q == 4'd8) begin
        s8_d = rx_s;
      end else begin
        s7_d = s7_q;
      end
    end else begin
      idx_d = idx_q;
    end

    case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          state_d    = S_START;
          idx_d      = 4'd0;
          bit_cnt_d  = 3'd0;
          last_bit_d = {1'b0, data_bits} + 3'd4;
          par_en_d   = parity_en;
          par_type_d = parity_type;
          stop2_d    = stop_bits;
          data_d     = 8'h00;
          par_acc_d  = 1'b0;
          any_one_d  = 1'b0;
          ferr_d     = 1'b0;
          perr_d     = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (sample_s && maj_s) begin
          state_d     = S_IDLE;
          start_err_d = 1'b1;
        end else if (bit_end_s) begin
          state_d = S_DATA;
        end else begin
          state_d = S_START;
        end
      end
      S_DATA: begin
        if (sample_s) begin
          data_d[bit_cnt_q] = maj_s;
          par_acc_d         = par_acc_q ^ maj_s;
          any_one_d         = any_one_q | maj_s;
        end else begin
          data_d = data_q;
        end
        if (bit_end_s) begin
          if (bit_cnt_q == last_bit_q) begin
            bit_cnt_d = 3'd0;
            state_d   = par_en_q ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q;
        end
      end
      S_PARITY: begin
        if (sample_s) begin
          perr_d    = par_acc_q ^ maj_s ^ par_type_q;
          any_one_d = any_one_q | maj_s;
        end else if (bit_end_s) begin
          state_d = S_STOP;
        end else begin
          state_d = S_PARITY;
        end
      end
      S_STOP: begin
        if (sample_s) begin
          ferr_d    = ferr_q | ~maj_s;
          any_one_d = any_one_q | maj_s;
          finish_s  = ~stop2_q;
        end else if (bit_end_s) begin
          state_d = S_STOP2;
        end else begin
          state_d = S_STOP;
        end
      end
      S_STOP2: begin
        if (sample_s) begin
          ferr_d    = ferr_q | ~maj_s;
          any_one_d = any_one_q | maj_s;
          finish_s  = 1'b1;
        end else begin
          state_d = S_STOP2;
        end
      end
      S_BRK_WAIT: begin
        if (rx_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_BRK_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Ending mid-stop-bit lets the receiver catch a start bit that follows immediately.
    if (finish_s) begin
      push_d  = 1'b1;
      entry_d = {~any_one_d, ferr_d, perr_q, data_q};
      state_d = any_one_d ? S_IDLE : S_BRK_WAIT;
    end else begin
      push_d = 1'b0;
    end
  end

  // FIFO bookkeeping: a push into a full FIFO only lands when a pop frees a slot that cycle.
  always_comb begin
    full_s    = (count_q == CW'(FIFO_DEPTH));
    pop_s     = (count_q != {CW{1'b0}}) && m_ready;
    wr_s      = push_q && (!full_s || pop_s);
    overrun_d = push_q && full_s && !pop_s;
    mem_d     = mem_q;
    if (wr_s) begin
      mem_d[wr_ptr_q] = entry_q;
      wr_ptr_d        = wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    count_d = count_q + CW'(wr_s) - CW'(pop_s);
  end

  // Control and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      sync_q      <= {SYNC_STAGES{1'b1}};
      div_cnt_q   <= {DIV_W{1'b0}};
      idx_q       <= 4'd0;
      s7_q        <= 1'b1;
      s8_q        <= 1'b1;
      bit_cnt_q   <= 3'd0;
      last_bit_q  <= 3'd7;
      par_en_q    <= 1'b0;
      par_type_q  <= 1'b0;
      stop2_q     <= 1'b0;
      data_q      <= 8'h00;
      par_acc_q   <= 1'b0;
      any_one_q   <= 1'b0;
      ferr_q      <= 1'b0;
      perr_q      <= 1'b0;
      push_q      <= 1'b0;
      entry_q     <= 11'h000;
      start_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      wr_ptr_q    <= {AW{1'b0}};
      rd_ptr_q    <= {AW{1'b0}};
      count_q     <= {CW{1'b0}};
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      div_cnt_q   <= div_cnt_d;
      idx_q       <= idx_d;
      s7_q        <= s7_d;
      s8_q        <= s8_d;
      bit_cnt_q   <= bit_cnt_d;
      last_bit_q  <= last_bit_d;
      par_en_q    <= par_en_d;
      par_type_q  <= par_type_d;
      stop2_q     <= stop2_d;
      data_q      <= data_d;
      par_acc_q   <= par_acc_d;
      any_one_q   <= any_one_d;
      ferr_q      <= ferr_d;
      perr_q      <= perr_d;
      push_q      <= push_d;
      entry_q     <= entry_d;
      start_err_q <= start_err_d;
      overrun_q   <= overrun_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // FIFO storage; entries beyond the occupancy are never shown, so no reset is needed.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head_s     = mem_q[rd_ptr_q];
  assign m_valid    = (count_q != {CW{1'b0}});
  assign m_data     = m_valid ? head_s[7:0] : 8'h00;
  assign m_flags    = m_valid ? head_s[10:8] : 3'b000;
  assign fifo_count = count_q;
  assign busy       = (state_q != S_IDLE);
  assign start_err  = start_err_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os: frames are modelled from the bit-level line
// rules, expected entries are queued and a monitor compares every popped entry.
module tb_uart_rx_os;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rstn, rx;
  logic [15:0] baud_div;
  logic [1:0]  data_bits;
  logic        parity_en, parity_type, stop_bits;
  logic [7:0]  m_data;
  logic [2:0]  m_flags;
  logic        m_valid, m_ready;
  logic [4:0]  fifo_count;
  logic        busy, start_err, overrun;

  always #5 clk = ~clk;

  uart_rx_os #(.DIV_W(16), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
    .clk(clk), .rstn(rstn), .rx(rx), .baud_div(baud_div), .data_bits(data_bits),
    .parity_en(parity_en), .parity_type(parity_type), .stop_bits(stop_bits),
    .m_data(m_data), .m_flags(m_flags), .m_valid(m_valid), .m_ready(m_ready),
    .fifo_count(fifo_count), .busy(busy), .start_err(start_err), .overrun(overrun)
  );

  int vectors = 0, miscompares = 0;
  int n_overrun = 0, n_start_err = 0, exp_overrun = 0;
  logic [10:0] exp_q[$];
  logic [10:0] mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected entry {break, frame_err, parity_err, data} from what was put on the line.
  function automatic logic [10:0] model(input logic [7:0] d, input int nb, input logic pen,
                                        input logic ptype, input logic pbit, input logic s1,
                                        input logic s2, input logic two);
    logic [7:0] mask, dm;
    logic pe, fe, brk;
    mask = 8'hFF >> (8 - nb);
    dm   = d & mask;
    pe   = pen && (((^dm) ^ pbit) != ptype);
    fe   = !s1 || (two && !s2);
    brk  = (dm == 8'h00) && (!pen || !pbit) && !s1 && (!two || !s2);
    return {brk, fe, pe, dm};
  endfunction

  // Monitor: compares each entry the consumer accepts and counts status pulses.
  always begin
    @(negedge clk);
    #2;
    if (rstn) begin
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_entry: got data 0x%0h flags %b, expected no entry", m_data, m_flags);
        end else begin
          mon_e = exp_q.pop_front();
          check("rx_data", 32'(m_data), 32'(mon_e[7:0]));
          check("rx_flags", 32'(m_flags), 32'(mon_e[10:8]));
        end
      end
      if (overrun) n_overrun++;
      if (start_err) n_start_err++;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic hold_bits(input logic v, input int nticks);
    rx = v;
    repeat (nticks * (int'(baud_div) + 1)) @(posedge clk);
    #1;
  endtask

  task automatic drive_frame(input logic [7:0] d, input int nb, input logic pen, input logic ptype,
                             input logic pbit, input logic s1, input logic s2, input logic two);
    data_bits   = 2'(nb - 5);
    parity_en   = pen;
    parity_type = ptype;
    stop_bits   = two;
    hold_bits(1'b0, 16);
    // configuration must already be latched; disturb it for the rest of the frame
    data_bits   = 2'($urandom);
    parity_en   = 1'($urandom);
    parity_type = 1'($urandom);
    stop_bits   = 1'($urandom);
    for (int i = 0; i < nb; i++) hold_bits(d[i], 16);
    if (pen) hold_bits(pbit, 16);
    hold_bits(s1, 16);
    if (two) hold_bits(s2, 16);
    hold_bits(1'b1, 32);
  endtask

  task automatic send(input logic [7:0] d, input int nb, input logic pen, input logic ptype,
                      input logic pbit, input logic s1, input logic s2, input logic two);
    if (exp_q.size() >= DEPTH) exp_overrun++;
    else exp_q.push_back(model(d, nb, pen, ptype, pbit, s1, s2, two));
    drive_frame(d, nb, pen, ptype, pbit, s1, s2, two);
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || m_valid) && t < 4000) begin
      @(negedge clk);
      t++;
    end
    check("drain_remaining", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int t, ov0, se0;
    rx = 1'b1; rstn = 1'b0; m_ready = 1'b0; baud_div = 16'd5;
    data_bits = 2'b11; parity_en = 1'b1; parity_type = 1'b0; stop_bits = 1'b0;
    repeat (4) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_m_flags", 32'(m_flags), 32'd0);
    check("rst_fifo_count", 32'(fifo_count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pulses", 32'({start_err, overrun}), 32'd0);
    @(posedge clk); #1;

    // 8E1, correct parity, held in the FIFO until inspected
    send(8'hA3, 8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    check("8e1_count", 32'(fifo_count), 32'd1);
    check("8e1_busy", 32'(busy), 32'd0);
    check("8e1_valid", 32'(m_valid), 32'd1);
    #1 m_ready = 1'b1;
    wait_drain();

    // 8O1 with wrong then right parity bit; 7N2 bad second stop; 5N1
    baud_div = 16'd2; @(posedge clk); #1;
    send(8'hA3, 8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    send(8'hA3, 8, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    send(8'h55, 7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    send(8'h1F, 5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    wait_drain();

    // runt start bit
    se0 = n_start_err;
    hold_bits(1'b0, 3);
    hold_bits(1'b1, 32);
    check("start_err_pulses", 32'(n_start_err - se0), 32'd1);
    check("start_err_busy", 32'(busy), 32'd0);

    // reset in the middle of the data bits
    data_bits = 2'b11; parity_en = 1'b0; stop_bits = 1'b0;
    hold_bits(1'b0, 16);
    hold_bits(1'b1, 16);
    hold_bits(1'b0, 8);
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1 rx = 1'b1; rstn = 1'b1;
    @(negedge clk);
    check("midrst_count", 32'(fifo_count), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    hold_bits(1'b1, 48);
    check("midrst_valid", 32'(m_valid), 32'd0);

    // fill past capacity with the consumer stalled
    baud_div = 16'd1; m_ready = 1'b0;
    ov0 = n_overrun;
    for (int i = 0; i <= DEPTH; i++) send(8'(i), 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    check("full_count", 32'(fifo_count), 32'd16);
    check("overrun_pulses", 32'(n_overrun - ov0), 32'd1);
    // one more frame, popped in the very cycle it is pushed
    exp_q.push_back(model(8'h11, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
    fork
      drive_frame(8'h11, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      begin
        t = 0;
        while (!busy && t < 3000) begin @(negedge clk); t++; end
        while (busy && t < 3000) begin @(negedge clk); t++; end
        check("coinc_wait_ok", 32'(t < 3000), 32'd1);
        #1 m_ready = 1'b1;
        @(posedge clk);
        #1 m_ready = 1'b0;
      end
    join
    @(negedge clk);
    check("coinc_count", 32'(fifo_count), 32'd16);
    check("coinc_overrun", 32'(n_overrun - ov0), 32'd1);
    #1 m_ready = 1'b1;
    wait_drain();

    // line held low for two 8E1 frame times
    baud_div = 16'd2;
    data_bits = 2'b11; parity_en = 1'b1; parity_type = 1'b0; stop_bits = 1'b0;
    exp_q.push_back(model(8'h00, 8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    hold_bits(1'b0, 22 * 16);
    check("brk_count", 32'(fifo_count), 32'd0);
    check("brk_busy", 32'(busy), 32'd1);
    hold_bits(1'b1, 64);
    wait_drain();
    check("brk_idle", 32'(busy), 32'd0);

    // randomised formats, data, parity and stop bits
    for (int n = 0; n < 24; n++) begin
      baud_div = 16'($urandom_range(0, 4));
      @(posedge clk); #1;
      send(8'($urandom), $urandom_range(5, 8), 1'($urandom), 1'($urandom), 1'($urandom),
           ($urandom_range(0, 5) != 0), ($urandom_range(0, 5) != 0), 1'($urandom));
    end
    wait_drain();
    check("total_overruns", 32'(n_overrun), 32'(exp_overrun));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
